// File: rtl/sample_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sample_frame_packer
//  Description : Collects a serial stream of DATA_W-bit samples from a
//                valid/ready source and packs them into a DEPTH-word frame
//                presented on a registered valid/ready output. A frame closes
//                on the DEPTH-th word or on a word tagged in_last; unfilled
//                slots of a short frame carry PAD_VALUE and out_len reports
//                the number of real words (1..DEPTH).
//
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                in_valid   - source word valid
//                in_ready   - word accepted this cycle when in_valid is high
//                in_data    - sample word
//                in_last    - accepted word closes the frame early
//                out_valid  - frame valid
//                out_ready  - sink accepts frame
//                out_frame  - frame words, index 0 = first word received
//                out_len    - number of real words in the frame
//
//  Options     : SFP_TIMEOUT_EN - when defined, a partial frame is flushed
//                after TIMEOUT_CYC idle cycles without an accepted word.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_frame_packer #(
    parameter int                DATA_W      = 10,
    parameter int                DEPTH       = 5,
    parameter logic [DATA_W-1:0] PAD_VALUE   = '0,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_frame [0:DEPTH-1],
    output logic [$clog2(DEPTH+1)-1:0]   out_len
);

    localparam int                 c_IDX_W    = $clog2(DEPTH);
    localparam int                 c_LEN_W    = $clog2(DEPTH + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DEPTH - 1);

    localparam logic [0:0] c_ST_FILL = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2) begin : g_bad_depth
        $error("sample_frame_packer: DEPTH must be >= 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("sample_frame_packer: TIMEOUT_CYC must be >= 1");
    end

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_wr_idx;
    logic [c_LEN_W-1:0] r_len;
    logic [DATA_W-1:0]  r_frame [0:DEPTH-1];
    logic               w_accept;
    logic               w_fill_close;
    logic               w_timeout;

    assign w_accept     = in_valid && in_ready;
    // Closing word in FILL: either the frame is now full or the source ends it.
    assign w_fill_close = (r_state == c_ST_FILL) && w_accept &&
                          (in_last || (r_wr_idx == c_LAST_IDX));

`ifdef SFP_TIMEOUT_EN
    localparam int c_TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_TMR_W-1:0] r_idle_cnt;
    logic               w_idle_run;

    // Counter value N means N idle cycles have already elapsed since the last
    // accept, so the flush fires on the TIMEOUT_CYC-th idle cycle's edge.
    assign w_idle_run = (r_state == c_ST_FILL) && (r_wr_idx != '0) && !w_accept;
    assign w_timeout  = w_idle_run && (r_idle_cnt == c_TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (w_idle_run && !w_timeout) begin
            r_idle_cnt <= r_idle_cnt + c_TMR_W'(1);
        end else begin
            r_idle_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_FILL: begin
                if (w_fill_close || w_timeout) begin
                    w_state_nxt = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                // A word tagged in_last arriving with the handshake forms a
                // one-word frame on its own, so the FSM stays in HOLD.
                if (out_ready && !(w_accept && in_last)) begin
                    w_state_nxt = c_ST_FILL;
                end
            end
            default: w_state_nxt = c_ST_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = (r_state == c_ST_HOLD);
        if (!rst) begin
            // In HOLD the input only moves when the held frame leaves.
            in_ready = (r_state == c_ST_FILL) ? 1'b1 : out_ready;
        end
    end

    // ------------------------------------------------------------------
    // Frame storage, write index and length
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx <= '0;
            r_len    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_frame[i] <= PAD_VALUE;
            end
        end else begin
            case (r_state)
                c_ST_FILL: begin
                    if (w_accept) begin
                        r_frame[r_wr_idx] <= in_data;
                        if (w_fill_close) begin
                            for (int i = 0; i < DEPTH; i++) begin
                                if (i > int'(r_wr_idx)) begin
                                    r_frame[i] <= PAD_VALUE;
                                end
                            end
                            r_len    <= c_LEN_W'(r_wr_idx) + c_LEN_W'(1);
                            r_wr_idx <= '0;
                        end else begin
                            r_wr_idx <= r_wr_idx + c_IDX_W'(1);
                        end
                    end else if (w_timeout) begin
                        // Flush: r_wr_idx already counts the real words.
                        for (int i = 0; i < DEPTH; i++) begin
                            if (i >= int'(r_wr_idx)) begin
                                r_frame[i] <= PAD_VALUE;
                            end
                        end
                        r_len    <= c_LEN_W'(r_wr_idx);
                        r_wr_idx <= '0;
                    end
                end
                c_ST_HOLD: begin
                    if (out_ready) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            r_frame[i] <= PAD_VALUE;
                        end
                        if (w_accept) begin
                            r_frame[0] <= in_data;
                            if (in_last) begin
                                r_len    <= c_LEN_W'(1);
                                r_wr_idx <= '0;
                            end else begin
                                r_len    <= '0;
                                r_wr_idx <= c_IDX_W'(1);
                            end
                        end else begin
                            r_len    <= '0;
                            r_wr_idx <= '0;
                        end
                    end
                end
                default: begin
                    r_wr_idx <= '0;
                end
            endcase
        end
    end

    assign out_frame = r_frame;
    assign out_len   = r_len;

endmodule
`default_nettype wire
